shift_register_sipo: RTL and testbench



---
 rtl/shift_register_sipo.sv | 79 +++++++
 tb/tb_shift_register_sipo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_register_sipo.sv
// Serial-in/parallel-out shift register with storage register, output enable,
// cascade output and frame counter. Define AUTO_LATCH_EN to latch each completed frame.
module shift_register_sipo #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             shift_en,
    input  logic             shift_dir,
    input  logic             latch,
    input  logic             clr,
    input  logic             oe_n,
    output logic [WIDTH-1:0] q,
    output logic             qs,
    output logic [CNT_W-1:0] bit_count,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] stor;
    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             wrap;

    always_comb begin
        shifted = sreg;
        if (shift_dir) begin
            shifted = {din, sreg[WIDTH-1:1]};
        end else begin
            shifted = {sreg[WIDTH-2:0], din};
        end
    end

    assign accept = shift_en && !clr;
    assign wrap   = accept && (bit_count == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg       <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            sreg       <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
        end else if (shift_en) begin
            sreg       <= shifted;
            bit_count  <= wrap ? '0 : bit_count + CNT_W'(1);
            frame_done <= wrap;
        end else begin
            frame_done <= 1'b0;
        end
    end

    // stor samples the pre-edge sreg, so a concurrent shift or clear is not seen
    always_ff @(posedge clk) begin
        if (reset) begin
            stor <= '0;
        end else begin
            if (latch) begin
                stor <= sreg;
            end
`ifdef AUTO_LATCH_EN
            if (wrap) begin
                stor <= shifted;
            end
`endif
        end
    end

    // Outputs are forced low during reset so stale state never leaks out
    assign q  = (reset || oe_n) ? '0 : stor;
    assign qs = reset ? 1'b0 : (shift_dir ? sreg[0] : sreg[WIDTH-1]);

endmodule

// File: tb/tb_shift_register_sipo.sv
// Scoreboard bench for shift_register_sipo (WIDTH=8); honours AUTO_LATCH_EN.
module tb_shift_register_sipo;

    logic       clk = 1'b0;
    logic       reset, din, shift_en, shift_dir, latch, clr, oe_n;
    logic [7:0] q;
    logic       qs;
    logic [3:0] bit_count;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       qs;
        logic [3:0] cnt;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_sreg = '0;
    logic [7:0] m_stor = '0;
    int         m_cnt  = 0;
    logic       m_fd   = 1'b0;

    shift_register_sipo #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .shift_en   (shift_en),
        .shift_dir  (shift_dir),
        .latch      (latch),
        .clr        (clr),
        .oe_n       (oe_n),
        .q          (q),
        .qs         (qs),
        .bit_count  (bit_count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare after the edge
    task automatic cycle(input string tag, input logic r, input logic d, input logic en,
                         input logic dir, input logic lat, input logic c, input logic oe);
        logic [7:0] old;
        logic       wrap;
        exp_t       e;
        exp_t       got;
        @(negedge clk);
        reset = r; din = d; shift_en = en; shift_dir = dir; latch = lat; clr = c; oe_n = oe;
        wrap = 1'b0;
        old  = m_sreg;
        if (r) begin
            m_sreg = '0; m_stor = '0; m_cnt = 0; m_fd = 1'b0;
        end else begin
            if (c) begin
                m_sreg = '0; m_cnt = 0; m_fd = 1'b0;
            end else if (en) begin
                if (dir) m_sreg = (m_sreg >> 1) | (8'(d) << 7);
                else     m_sreg = (m_sreg << 1) | 8'(d);
                wrap  = (m_cnt == 7);
                m_cnt = wrap ? 0 : m_cnt + 1;
                m_fd  = wrap;
            end else begin
                m_fd = 1'b0;
            end
            if (lat) m_stor = old;
`ifdef AUTO_LATCH_EN
            if (wrap) m_stor = m_sreg;
`endif
        end
        e.tag = tag;
        e.q   = (r || oe) ? 8'h00 : m_stor;
        e.qs  = r ? 1'b0 : (dir ? m_sreg[0] : m_sreg[7]);
        e.cnt = 4'(m_cnt);
        e.fd  = m_fd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".q"},   32'(q),          32'(got.q));
        check({got.tag, ".qs"},  32'(qs),         32'(got.qs));
        check({got.tag, ".cnt"}, 32'(bit_count),  32'(got.cnt));
        check({got.tag, ".fd"},  32'(frame_done), 32'(got.fd));
    endtask

    task automatic shift_byte(input string tag, input logic [7:0] v, input logic dir,
                              input logic lat_last);
        for (int i = 0; i < 8; i++) begin
            cycle(tag, 1'b0, v[7-i], 1'b1, dir, (i == 7) ? lat_last : 1'b0, 1'b0, 1'b0);
            check({tag, ".step_cnt"}, 32'(bit_count), 32'((i + 1) % 8));
            check({tag, ".step_fd"},  32'(frame_done), 32'(i == 7));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; din = 1'b0; shift_en = 1'b0; shift_dir = 1'b0;
        latch = 1'b0; clr = 1'b0; oe_n = 1'b0;

        cycle("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_q", 32'(q), 32'h00);

        // Reset mid-frame
        cycle("pre", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("pre", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("pre", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_q", 32'(q), 32'h00);
        check("after_rst_cnt", 32'(bit_count), 32'h0);
        check("after_rst_qs", 32'(qs), 32'h0);

        // MSB-direction frame
        shift_byte("dir0", 8'hB2, 1'b0, 1'b0);
        cycle("dir0_latch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dir0_q", 32'(q), 32'hB2);

        // LSB-direction frame from a cleared register
        cycle("clr1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("dir1_first", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dir1_first_qs", 32'(qs), 32'h0);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'hB2;
            cycle("dir1", 1'b0, pat[7-i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cycle("dir1_latch", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("dir1_q", 32'(q), 32'h4D);

        // Latch concurrent with the final shift sees the pre-shift value
        cycle("clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_byte("load", 8'hB2, 1'b0, 1'b0);
        cycle("load_latch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("load_q", 32'(q), 32'hB2);
        shift_byte("ones", 8'hFF, 1'b0, 1'b1);
`ifdef AUTO_LATCH_EN
        check("ones_q", 32'(q), 32'hFF);
`else
        check("ones_q", 32'(q), 32'h7F);
`endif
        cycle("ones_latch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ones_latch_q", 32'(q), 32'hFF);

        // clr leaves stor alone; oe_n gates q
        cycle("clr3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        shift_byte("stor", 8'hB2, 1'b0, 1'b0);
        cycle("stor_latch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle("five", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("clr_shift", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_cnt", 32'(bit_count), 32'h0);
        check("clr_q", 32'(q), 32'hB2);
        check("clr_qs", 32'(qs), 32'h0);
        cycle("oe_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("oe_off_q", 32'(q), 32'h00);
        cycle("oe_on", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("oe_on_q", 32'(q), 32'hB2);

        // Frame completion without an explicit latch
        shift_byte("auto", 8'h3C, 1'b0, 1'b0);
`ifdef AUTO_LATCH_EN
        check("auto_q", 32'(q), 32'h3C);
`else
        check("auto_q", 32'(q), 32'hB2);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
